// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: register-file geometry and the
// architectural zero register. Used by the writeback stage, hazard unit
// and the integer register file.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   typedef logic [AW-1:0]   reg_addr_t;
   typedef logic [XLEN-1:0] xlen_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage : riscv_pkg

// File: rtl/regfile_rdport.sv
// One combinational register-file read port: array select, optional
// same-cycle writeback bypass, and the x0 guard. The x0 guard is applied
// last so that address 0 reads zero regardless of what the bypass sees.
module regfile_rdport
   import riscv_pkg::*;
#(
   parameter int XLEN   = riscv_pkg::XLEN,
   parameter int NREG   = riscv_pkg::NREG,
   parameter int AW     = riscv_pkg::AW,
   parameter bit BYPASS = 1'b0
) (
   input  logic [NREG-1:0][XLEN-1:0] regs,
   input  logic [AW-1:0]             addr,
   input  logic                      byp_valid,
   input  logic [AW-1:0]             byp_addr,
   input  logic [XLEN-1:0]           byp_data,
   output logic [XLEN-1:0]           data
);

   // Select stored value, override with in-flight writeback data, force x0 to zero.
   always_comb begin
      data = regs[addr];
      if (BYPASS && byp_valid && (byp_addr == addr)) begin
         data = byp_data;
      end
      if (addr == REG_ZERO) begin
         data = '0;
      end
   end

endmodule : regfile_rdport

// File: rtl/regfile_wb.sv
// Integer register file at the consumer end of the writeback interface.
// 31 stored registers (x0 hard-wired to zero), two decode read ports, one
// never-bypassed debug read port and a wrapping count of committed writes.
// Optional feature macro: REGFILE_BYPASS_EN enables the same-cycle
// write-to-read bypass on the two decode ports. Without it, decode sees
// new data one cycle after the write edge and the hazard unit stalls.
module regfile_wb
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter int NREG = riscv_pkg::NREG,
   parameter int AW   = riscv_pkg::AW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RegWriteW,
   input  logic [AW-1:0]   rdW,
   input  logic [XLEN-1:0] ResultW,
   input  logic [AW-1:0]   rs1D,
   input  logic [AW-1:0]   rs2D,
   output logic [XLEN-1:0] RD1D,
   output logic [XLEN-1:0] RD2D,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   output logic [31:0]     wr_count
);

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [NREG-1:0][XLEN-1:0] regs;
   logic                      wr_en;
   logic                      byp_valid;

   // RegWriteW gates first so an unknown rdW with no write pending cannot enable anything.
   assign wr_en     = RegWriteW && (rdW != REG_ZERO);
   // Bypass is held off during reset so decode reads the cleared array.
   assign byp_valid = wr_en && reset;

   assign regs[0] = '0;

   for (genvar i = 1; i < NREG; i++) begin : g_reg
      logic [XLEN-1:0] q;

      // Register x[i]: cleared asynchronously, loaded when addressed by a valid write.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            q <= '0;
         end else if (wr_en && (rdW == AW'(i))) begin
            q <= ResultW;
         end
      end

      assign regs[i] = q;
   end

   // Count committed writes; wraps silently at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_count <= '0;
      end else if (wr_en) begin
         wr_count <= wr_count + 32'd1;
      end
   end

   regfile_rdport #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .AW     (AW),
      .BYPASS (BYPASS)
   ) u_rd1 (
      .regs      (regs),
      .addr      (rs1D),
      .byp_valid (byp_valid),
      .byp_addr  (rdW),
      .byp_data  (ResultW),
      .data      (RD1D)
   );

   regfile_rdport #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .AW     (AW),
      .BYPASS (BYPASS)
   ) u_rd2 (
      .regs      (regs),
      .addr      (rs2D),
      .byp_valid (byp_valid),
      .byp_addr  (rdW),
      .byp_data  (ResultW),
      .data      (RD2D)
   );

   regfile_rdport #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .AW     (AW),
      .BYPASS (1'b0)
   ) u_dbg (
      .regs      (regs),
      .addr      (dbg_addr),
      .byp_valid (1'b0),
      .byp_addr  (rdW),
      .byp_data  (ResultW),
      .data      (dbg_data)
   );

endmodule : regfile_wb

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed vector table, hand-written
// bypass / reset / counter-wrap sequences, and randomized traffic checked
// against an array-based model of the architectural register state.
module tb_regfile_wb;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        RegWriteW;
   logic [4:0]  rdW;
   logic [31:0] ResultW;
   logic [4:0]  rs1D;
   logic [4:0]  rs2D;
   logic [31:0] RD1D;
   logic [31:0] RD2D;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [31:0] wr_count;

   regfile_wb dut (
      .clk       (clk),
      .reset     (reset),
      .RegWriteW (RegWriteW),
      .rdW       (rdW),
      .ResultW   (ResultW),
      .rs1D      (rs1D),
      .rs2D      (rs2D),
      .RD1D      (RD1D),
      .RD2D      (RD2D),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .wr_count  (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [31:0] ecnt;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
   endtask

   // Architectural view of a read port given the current writeback inputs.
   function automatic logic [31:0] model_read(input logic [4:0] a, input bit bypassable);
      if (a == 5'd0) return 32'd0;
      if (bypassable && BYP && reset && RegWriteW && (rdW == a)) return ResultW;
      return m_regs[a];
   endfunction

   // Advance one rising edge and commit the pending write into the model.
   task automatic step();
      @(posedge clk);
      if (reset && RegWriteW && (rdW != 5'd0)) begin
         m_regs[rdW] = ResultW;
         m_cnt       = m_cnt + 32'd1;
      end
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      RegWriteW = 1'b0;
      rdW       = '0;
      ResultW   = '0;
      rs1D      = 5'd5;
      rs2D      = 5'd17;
      dbg_addr  = 5'd9;
      model_clear();

      tbl[0] = '{1'b1, 5'd3,  32'h0000_1010, 5'd3,  5'd0,  32'h0000_1010, 32'h0000_0000, 32'd1};
      tbl[1] = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000, 32'd1};
      tbl[2] = '{1'b0, 5'd9,  32'hFFFF_FFFF, 5'd9,  5'd3,  32'h0000_0000, 32'h0000_1010, 32'd1};
      tbl[3] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd2};
      tbl[4] = '{1'b1, 5'd3,  32'h0BAD_F00D, 5'd3,  5'd31, 32'h0BAD_F00D, 32'hA5A5_A5A5, 32'd3};
      tbl[5] = '{1'b1, 5'd7,  32'h0000_0077, 5'd7,  5'd1,  32'h0000_0077, 32'h0000_0000, 32'd4};

      // Reset state.
      #12;
      chk("reset_rd1", RD1D, 32'd0);
      chk("reset_rd2", RD2D, 32'd0);
      chk("reset_dbg", dbg_data, 32'd0);
      chk("reset_cnt", wr_count, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed vectors.
      for (int v = 0; v < 6; v++) begin
         @(negedge clk);
         RegWriteW = tbl[v].we;
         rdW       = tbl[v].rd;
         ResultW   = tbl[v].data;
         rs1D      = tbl[v].rs1;
         rs2D      = tbl[v].rs2;
         step();
         RegWriteW = 1'b0;
         #1;
         chk($sformatf("tbl%0d_rd1", v), RD1D, tbl[v].e1);
         chk($sformatf("tbl%0d_rd2", v), RD2D, tbl[v].e2);
         chk($sformatf("tbl%0d_cnt", v), wr_count, tbl[v].ecnt);
      end

      // Same-cycle write/read on x7 (old value 0x77).
      @(negedge clk);
      rs1D      = 5'd7;
      rs2D      = 5'd7;
      dbg_addr  = 5'd7;
      RegWriteW = 1'b1;
      rdW       = 5'd7;
      ResultW   = 32'h0040_0004;
      #1;
      chk("byp_rd1", RD1D, BYP ? 32'h0040_0004 : 32'h0000_0077);
      chk("byp_rd2", RD2D, BYP ? 32'h0040_0004 : 32'h0000_0077);
      chk("byp_dbg", dbg_data, 32'h0000_0077);
      step();
      RegWriteW = 1'b0;
      #1;
      chk("byp_after_rd1", RD1D, 32'h0040_0004);
      chk("byp_after_dbg", dbg_data, 32'h0040_0004);
      chk("byp_after_cnt", wr_count, 32'd5);

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         RegWriteW = ($urandom_range(0, 3) != 0);
         rs1D      = 5'($urandom);
         rs2D      = ($urandom_range(0, 5) == 0) ? rs1D : 5'($urandom);
         dbg_addr  = ($urandom_range(0, 3) == 0) ? rs1D : 5'($urandom);
         rdW       = ($urandom_range(0, 3) == 0) ? rs1D : 5'($urandom);
         ResultW   = $urandom;
         #1;
         chk("rnd_rd1", RD1D, model_read(rs1D, 1'b1));
         chk("rnd_rd2", RD2D, model_read(rs2D, 1'b1));
         chk("rnd_dbg", dbg_data, model_read(dbg_addr, 1'b0));
         chk("rnd_cnt", wr_count, m_cnt);
         step();
      end

      // Asynchronous reset mid-cycle, with a write pending to x5.
      @(negedge clk);
      RegWriteW = 1'b1;
      rdW       = 5'd5;
      ResultW   = 32'hDEAD_BEEF;
      step();
      rs1D      = 5'd5;
      rs2D      = 5'd5;
      dbg_addr  = 5'd5;
      ResultW   = 32'h1111_2222;
      #2;
      chk("pre_rst_dbg", dbg_data, 32'hDEAD_BEEF);
      reset = 1'b0;
      model_clear();
      #1;
      chk("rst_async_rd1", RD1D, 32'd0);
      chk("rst_async_rd2", RD2D, 32'd0);
      chk("rst_async_dbg", dbg_data, 32'd0);
      chk("rst_async_cnt", wr_count, 32'd0);
      step();
      chk("rst_hold_rd1", RD1D, 32'd0);
      chk("rst_hold_cnt", wr_count, 32'd0);
      @(negedge clk);
      reset     = 1'b1;
      RegWriteW = 1'b0;
      #1;
      chk("rst_rel_dbg", dbg_data, 32'd0);

      // First write after release, then counter wrap.
      @(negedge clk);
      RegWriteW = 1'b1;
      rdW       = 5'd2;
      ResultW   = 32'h0000_0042;
      step();
      RegWriteW = 1'b0;
      dbg_addr  = 5'd2;
      #1;
      chk("post_rel_dbg", dbg_data, 32'h0000_0042);
      chk("post_rel_cnt", wr_count, 32'd1);

      @(negedge clk);
      force dut.wr_count = 32'hFFFF_FFFF;
      #1;
      release dut.wr_count;
      m_cnt     = 32'hFFFF_FFFF;
      RegWriteW = 1'b1;
      rdW       = 5'd1;
      ResultW   = 32'hCAFE_0001;
      step();
      RegWriteW = 1'b0;
      rs1D      = 5'd1;
      #1;
      chk("wrap_cnt", wr_count, m_cnt);
      chk("wrap_cnt_zero", wr_count, 32'd0);
      chk("wrap_x1", RD1D, 32'hCAFE_0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_regfile_wb

// File: doc/regfile_wb.md
# regfile_wb

Integer register file for the 5-stage RISC-V pipeline: the consumer end of the writeback interface. Accepts RegWriteW/rdW/ResultW from the writeback stage, stores 32 x 32-bit architectural registers, and serves two combinational read ports to the decode stage. An optional same-cycle write-to-read bypass resolves the decode/writeback register hazard. A 32-bit write counter supports testbench bookkeeping.

## Interface
Parameters:
- XLEN, 32, register width
- NREG, 32, number of registers; register 0 is hard-wired to zero
- AW, 5, register address width (log2 NREG)

Ports:
- clk  in  1  single clock, rising-edge active
- reset  in  1  asynchronous, active-low; clears all state
- RegWriteW  in  1  write enable from writeback stage
- rdW  in  AW  destination register address
- ResultW  in  XLEN  writeback data
- rs1D  in  AW  decode read address 1
- rs2D  in  AW  decode read address 2
- RD1D  out  XLEN  read data 1
- RD2D  out  XLEN  read data 2
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  debug read data, never bypassed
- wr_count  out  32  count of committed writes

## Operation
- Storage: NREG-1 flops of XLEN bits, indices 1..NREG-1. Index 0 is not stored.
- Write: on a rising clk edge with reset high, RegWriteW=1 and rdW!=0 -> regs[rdW] <= ResultW, wr_count <= wr_count+1.
- Writes with rdW=0 are discarded and do not increment wr_count, whatever the value of RegWriteW.
- Reads are combinational. Address 0 returns 0 on every port in every configuration.
- Both read ports may address the same register; each returns the same value.
- wr_count wraps modulo 2^32 with no saturation or flag.
- Reset (reset=0): all registers <= 0 and wr_count <= 0 immediately, independent of clk. A write in the same cycle as reset assertion is lost. Release is synchronous to design intent: the first write is the first rising edge with reset=1.
- X on rdW while RegWriteW=0 has no effect on state.

## Timing
- Write latency: value visible on non-bypassed reads in the cycle after the write edge.
- With bypass: when RegWriteW=1, rdW!=0 and rdW==rs1D, RD1D=ResultW in the same cycle, with no flop in the path. RD2D behaves the same way for rs2D. dbg_data is excluded.
- Bypass is suppressed while reset=0; RD1D/RD2D then read 0.
- Output reset values: RD1D, RD2D, dbg_data = 0 for any address; wr_count = 0.
- Combinational path: rs*D/rdW/ResultW -> RD*D. No registered outputs except wr_count.

## Configuration
- REGFILE_BYPASS_EN defined: the same-cycle write-to-read bypass is as described under Timing, and decode sees the writeback value in the same cycle.
- REGFILE_BYPASS_EN undefined: reads return stored contents only. The hazard unit must then stall decode for one cycle on an rdW match.
- All other behaviour is identical in both configurations.

## Structure
- Shared package riscv_pkg holds XLEN, NREG, AW, the typedef reg_addr_t (AW bits), the typedef xlen_t (XLEN bits) and the constant REG_ZERO = 0. The writeback stage and the hazard unit use the same package.
- Sub-module regfile_rdport: a single read port covering the zero check, array select and optional bypass mux. It is instantiated three times (RD1D, RD2D, dbg_data), with bypass tied off on the debug instance.

## Test plan
- Reset: write x5=0xDEADBEEF, assert reset low mid-cycle -> RD1D(x5)=0 and wr_count=0 immediately, without waiting for a clk edge.
- Basic write/read: RegWriteW=1, rdW=3, ResultW=0x00001010 -> after the edge, RD1D(rs1D=3)=0x00001010, wr_count=1.
- x0 guard: RegWriteW=1, rdW=0, ResultW=0x12345678 -> RD1D(rs1D=0)=0, RD2D(rs2D=0)=0, wr_count unchanged.
- Bypass: rs1D=rs2D=7, RegWriteW=1, rdW=7, ResultW=0x00400004 before the edge.
  - With REGFILE_BYPASS_EN: RD1D=RD2D=0x00400004 in the same cycle, dbg_data(7)=old value.
  - Without REGFILE_BYPASS_EN: RD1D=old value until after the edge.
- Disabled write: RegWriteW=0, rdW=9, ResultW=0xFFFFFFFF -> x9 unchanged, wr_count unchanged.
- Counter wrap: force wr_count to 0xFFFFFFFF, then do one valid write to x1 -> wr_count=0 and x1 holds the written data.
